// File: rtl/vec_lane_serializer.sv
// ---------------------------------------------------------------------------
// vec_lane_serializer
//
// Streams selected 32-bit lanes of a 32*K-bit vector operand onto the scalar
// datapath, one lane per valid/ready transfer. A start pulse in IDLE captures
// the operand, the first lane index and the lane count. The block then walks
// the lane index itself, wrapping modulo K. An out-of-range first lane maps to
// lane 0, and the count is clamped to K so that no lane is emitted twice.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   reset_i      synchronous active-high reset; overrides every other input
//   start_i      one-cycle burst request; only accepted in IDLE
//   vec_i        vector operand, lane i = vec_i[32i+31:32i]
//   first_i      first lane index (unsigned)
//   count_i      number of lanes to emit (unsigned)
//   busy_o       high while a burst is running or finishing
//   out_valid_o  data_o / lane_o / last_o carry a word
//   out_ready_i  consumer accepts the current word
//   data_o       current lane data (0 when no word is offered)
//   lane_o       current lane index (0 when no word is offered)
//   last_o       current word is the final word of the burst
//   done_o       one-cycle pulse after the final transfer
// ---------------------------------------------------------------------------
module vec_lane_serializer #(
    parameter int unsigned K = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [32*K-1:0] vec_i,
    input  logic [31:0]     first_i,
    input  logic [31:0]     count_i,
    output logic            busy_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     data_o,
    output logic [31:0]     lane_o,
    output logic            last_o,
    output logic            done_o
);

    // Wide enough to hold both K-1 (lane index) and K (clamped count).
    localparam int IW = $clog2(K + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     rem_q, rem_d;
    logic [32*K-1:0]   buf_q, buf_d;

    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       lane_q, lane_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

    logic [31:0]       lane_data_s;

    // Next-state logic: capture on accepted start, advance on each transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    buf_d = vec_i;
                    idx_d = (first_i < 32'(K)) ? first_i[IW-1:0] : {IW{1'b0}};
                    rem_d = (count_i < 32'(K)) ? count_i[IW-1:0] : IW'(K);
                    if (rem_d == {IW{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // out_valid is always high in RUN, so ready alone means a transfer.
                if (out_ready_i) begin
                    idx_d = (idx_q == IW'(K - 1)) ? {IW{1'b0}} : idx_q + IW'(1);
                    rem_d = rem_q - IW'(1);
                    if (rem_q == IW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Lane multiplexer on the next-state buffer and index, so the output
    // registers already hold the word that belongs to the coming cycle.
    always_comb begin
        lane_data_s = 32'd0;
        for (int i = 0; i < int'(K); i++) begin
            lane_data_s = (idx_d == IW'(i)) ? buf_d[32*i +: 32] : lane_data_s;
        end
    end

    // Output values derived from the next state; registered below.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
        last_d  = valid_d && (rem_d == IW'(1));
        data_d  = valid_d ? lane_data_s : 32'd0;
        lane_d  = valid_d ? {{(32-IW){1'b0}}, idx_d} : 32'd0;
    end

    // State, operand buffer and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= {IW{1'b0}};
            rem_q   <= {IW{1'b0}};
            buf_q   <= {(32*K){1'b0}};
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 32'd0;
            lane_q  <= 32'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign out_valid_o = valid_q;
    assign data_o      = data_q;
    assign lane_o      = lane_q;
    assign last_o      = last_q;
    assign done_o      = done_q;

endmodule

// File: doc/vec_lane_serializer.md
# vec_lane_serializer

Streams selected 32-bit lanes of a 32·K-bit vector register operand onto the scalar datapath, one lane per transfer, under a valid/ready handshake. It sits beside the vector-to-scalar lane select unit, which handles single-element moves. It takes the same vector-register-file read word and uses the same out-of-range lane rule. It serves multi-element transfers, for example a vector store over the 32-bit memory port or a scalar reduction loop. A start pulse captures the operand, and the block then sequences lane indices itself, wrapping modulo K.

## Interface
- K, default 4 (instantiated with the global lane count `k`), number of 32-bit lanes; K ≥ 1.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- start  in  1  one-cycle request; accepted only in IDLE.
- vec_in  in  32·K  vector operand; lane i = vec_in[32i+31 : 32i]; sampled on accepted start.
- first_in  in  32  first lane index; sampled on accepted start.
- count_in  in  32  number of lanes to emit; sampled on accepted start.
- busy  out  1  high in RUN and DONE.
- out_valid  out  1  data_out/lane_out/last_out are valid.
- out_ready  in  1  consumer accepts the current word.
- data_out  out  32  current lane data.
- lane_out  out  32  index of the current lane, 0..K-1.
- last_out  out  1  current word is the final one of the burst; qualified by out_valid.
- done  out  1  one-cycle pulse: burst finished.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Register vec_in into an internal 32·K vector buffer.
  - idx ← (first_in < K) ? first_in : 0. An out-of-range first lane maps to lane 0, the same rule the lane select unit uses.
  - rem ← min(count_in, K). The count is clamped, so no lane is emitted twice.
  - If rem = 0, go to DONE. Otherwise go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN:
  - out_valid=1.
  - data_out = buffer lane idx; lane_out = idx.
  - last_out = (rem == 1).
- RUN, transfer (out_valid & out_ready):
  - idx ← (idx == K-1) ? 0 : idx+1, which wraps.
  - rem ← rem-1.
  - If rem was 1, go to DONE.
- RUN, no transfer: all outputs and state held stable; no word may change while out_valid is high and out_ready is low.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- start is ignored whenever busy=1; it is neither queued nor counted.
- Changes to vec_in, first_in or count_in after capture have no effect on a burst in progress.
- Arithmetic: idx and rem are at least clog2(K+1) bits internally and zero-extended on lane_out. Comparisons against K are unsigned 32-bit.
- reset (any state, including mid-burst):
  - State goes to IDLE; the burst is abandoned and no done pulse is issued.
  - Outputs go to busy=0, out_valid=0, last_out=0, done=0, data_out=0, lane_out=0.
  - The buffer is cleared to 0.
- Outside RUN, data_out and lane_out read 0.

## Timing
- Start accepted in cycle N → busy=1 and out_valid=1 with the first lane from cycle N+1. Registered outputs give one cycle of latency.
- With out_ready held high: one word per cycle, words at N+1 … N+rem, done at N+rem+1, busy=0 at N+rem+2. A new start is accepted in cycle N+rem+2.
- If rem = 0: done at N+1, no out_valid, busy=0 at N+2.
- Back-pressure: each low cycle of out_ready adds exactly one cycle; words are never dropped or duplicated.
- last_out rises together with the final word's out_valid and is never high at any other time.
- start asserted in the same cycle as reset is ignored.

## Test plan
- K=4, vec_in lanes {0:A0, 1:B1, 2:C2, 3:D3}, first=1, count=2, out_ready=1 → words B1 (lane 1), C2 (lane 2, last_out=1), done at N+3, busy low at N+4.
- Wrap case: first=3, count=3 → lanes 3, 0, 1 (D3, A0, B1); last_out on B1.
- Clamp and range case: first=7, count=9 → lanes 0, 1, 2, 3, exactly 4 words; count=0 → only done at N+1, out_valid never asserted.
- Back-pressure: first=0, count=4, out_ready toggled 1,0,0,1,1,0,1 → data held stable while stalled, 4 words in order A0..D3, done one cycle after the 4th transfer.
- Interrupted burst: reset asserted after the 2nd word of a 4-word burst → next cycle all outputs 0, no done; a fresh start then runs normally. A start during busy is ignored, and the burst length is unchanged.
- Operand isolation: vec_in changed to all-ones during RUN → emitted words still equal the captured values.
